// File: rtl/powerup_scheduler_if.sv
// Power-up scheduler bundle: game state, selector flags and pickup in,
// spawn request, field display and effect status out.
interface powerup_scheduler_if;
   logic       game_active;
   logic [3:0] LFSR_interval;
   logic       pickup;
   logic       speedup;
   logic       extralife;
   logic       shootfaster;
   logic       doublescore;
   logic       generate_powerup;
   logic       powerup_visible;
   logic       powerup_blink;
   logic       speed_active;
   logic       shoot_active;
   logic       double_active;
   logic       add_life;

   modport master (
      output game_active, LFSR_interval, pickup,
             speedup, extralife, shootfaster, doublescore,
      input  generate_powerup, powerup_visible, powerup_blink,
             speed_active, shoot_active, double_active, add_life
   );

   modport slave (
      input  game_active, LFSR_interval, pickup,
             speedup, extralife, shootfaster, doublescore,
      output generate_powerup, powerup_visible, powerup_blink,
             speed_active, shoot_active, double_active, add_life
   );
endinterface

// File: rtl/powerup_scheduler.sv
// Per-frame power-up sequencer: spawn timing, field lifetime with blink,
// pickup handling and independent effect duration timers.
module powerup_scheduler #(
   parameter int SPAWN_BASE  = 300,
   parameter int SPAWN_STEP  = 30,
   parameter int FIELD_TIME  = 600,
   parameter int BLINK_TIME  = 120,
   parameter int EFFECT_TIME = 480,
   parameter int CNT_W       = 12
) (
   input  logic               frame_clk,
   input  logic               Reset,
   powerup_scheduler_if.slave bus
);
   typedef enum logic [1:0] {IDLE, WAIT, SPAWN, FIELD} state_e;

   localparam logic [CNT_W-1:0] ZERO     = '0;
   localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);
   localparam logic [CNT_W-1:0] FIELD_T  = CNT_W'(FIELD_TIME);
   localparam logic [CNT_W-1:0] BLINK_T  = CNT_W'(BLINK_TIME);
   localparam logic [CNT_W-1:0] EFFECT_T = CNT_W'(EFFECT_TIME);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] spawn_cnt_q, spawn_cnt_d;
   logic [CNT_W-1:0] field_cnt_q, field_cnt_d;
   logic [CNT_W-1:0] speed_cnt_q, speed_cnt_d;
   logic [CNT_W-1:0] shoot_cnt_q, shoot_cnt_d;
   logic [CNT_W-1:0] dbl_cnt_q, dbl_cnt_d;
   logic             life_d;
   logic             gen_q, vis_q, blink_q, life_q;
   logic             speed_q, shoot_q, dbl_q;
   logic [CNT_W-1:0] n_raw, n_load;
   logic             take;

   function automatic logic [CNT_W-1:0] dec(input logic [CNT_W-1:0] v);
      return (v == ZERO) ? ZERO : v - ONE;
   endfunction

   assign n_raw  = CNT_W'(SPAWN_BASE)
                 + CNT_W'(bus.LFSR_interval) * CNT_W'(SPAWN_STEP);
   assign n_load = (n_raw == ZERO) ? ONE : n_raw;
   assign take   = (state_q == FIELD) && bus.pickup;

   always_comb begin
      state_d     = state_q;
      spawn_cnt_d = dec(spawn_cnt_q);
      field_cnt_d = dec(field_cnt_q);
      speed_cnt_d = dec(speed_cnt_q);
      shoot_cnt_d = dec(shoot_cnt_q);
      dbl_cnt_d   = dec(dbl_cnt_q);
      life_d      = take && bus.extralife;
      unique case (state_q)
         IDLE: begin
            if (bus.game_active) begin
               state_d     = WAIT;
               spawn_cnt_d = n_load;
            end
         end
         WAIT: begin
            if (spawn_cnt_q <= ONE) state_d = SPAWN;
         end
         SPAWN: begin
            state_d     = FIELD;
            field_cnt_d = FIELD_T;
         end
         FIELD: begin
            // pickup takes priority over expiry on the last field frame
            if (take || field_cnt_q <= ONE) begin
               state_d     = WAIT;
               spawn_cnt_d = n_load;
               field_cnt_d = ZERO;
            end
         end
      endcase
      if (take) begin
         if (bus.speedup)     speed_cnt_d = EFFECT_T;
         if (bus.shootfaster) shoot_cnt_d = EFFECT_T;
         if (bus.doublescore) dbl_cnt_d   = EFFECT_T;
      end
      // leaving the game wipes everything except an add_life already due
      if (!bus.game_active) begin
         state_d     = IDLE;
         spawn_cnt_d = ZERO;
         field_cnt_d = ZERO;
         speed_cnt_d = ZERO;
         shoot_cnt_d = ZERO;
         dbl_cnt_d   = ZERO;
      end
   end

   always_ff @(posedge frame_clk or posedge Reset) begin
      if (Reset) begin
         state_q     <= IDLE;
         spawn_cnt_q <= ZERO;
         field_cnt_q <= ZERO;
         speed_cnt_q <= ZERO;
         shoot_cnt_q <= ZERO;
         dbl_cnt_q   <= ZERO;
         gen_q       <= 1'b0;
         vis_q       <= 1'b0;
         blink_q     <= 1'b0;
         speed_q     <= 1'b0;
         shoot_q     <= 1'b0;
         dbl_q       <= 1'b0;
         life_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         spawn_cnt_q <= spawn_cnt_d;
         field_cnt_q <= field_cnt_d;
         speed_cnt_q <= speed_cnt_d;
         shoot_cnt_q <= shoot_cnt_d;
         dbl_cnt_q   <= dbl_cnt_d;
         gen_q       <= (state_d == SPAWN);
         vis_q       <= (state_d == FIELD);
         blink_q     <= (state_d == FIELD)
                     && (field_cnt_d <= BLINK_T)
                     && field_cnt_d[3];
         speed_q     <= (speed_cnt_d != ZERO);
         shoot_q     <= (shoot_cnt_d != ZERO);
         dbl_q       <= (dbl_cnt_d != ZERO);
         life_q      <= life_d;
      end
   end

   assign bus.generate_powerup = gen_q;
   assign bus.powerup_visible  = vis_q;
   assign bus.powerup_blink    = blink_q;
   assign bus.speed_active     = speed_q;
   assign bus.shoot_active     = shoot_q;
   assign bus.double_active    = dbl_q;
   assign bus.add_life         = life_q;
endmodule

// File: tb/tb_powerup_scheduler.sv
// Scoreboard bench for powerup_scheduler against a timestamp-based
// reference model; directed scenarios followed by random play.
module tb_powerup_scheduler;
   localparam int SB = 10;
   localparam int SS = 2;
   localparam int FT = 20;
   localparam int BT = 8;
   localparam int ET = 16;
   localparam int CW = 12;

   typedef logic [6:0] vec_t;

   logic frame_clk = 1'b0;
   logic Reset     = 1'b1;

   powerup_scheduler_if bus();

   powerup_scheduler #(
      .SPAWN_BASE(SB), .SPAWN_STEP(SS), .FIELD_TIME(FT),
      .BLINK_TIME(BT), .EFFECT_TIME(ET), .CNT_W(CW)
   ) dut (
      .frame_clk(frame_clk),
      .Reset(Reset),
      .bus(bus)
   );

   always #5 frame_clk = ~frame_clk;

   vec_t sb[$];
   int   checks = 0;
   int   errors = 0;
   int   mon_n  = 0;
   bit   rst_v  = 1'b1;

   // model: phase plus absolute edge timestamps of upcoming events
   int m_edge      = 0;
   int m_phase     = 0;
   int m_spawn_at  = 0;
   int m_field_end = 0;
   int m_end[3]    = '{0, 0, 0};
   bit m_life      = 1'b0;

   function automatic vec_t outs();
      return {bus.generate_powerup, bus.powerup_visible, bus.powerup_blink,
              bus.speed_active, bus.shoot_active, bus.double_active,
              bus.add_life};
   endfunction

   function automatic int n_of(logic [3:0] lf);
      int n;
      n = (SB + int'(lf) * SS) % (1 << CW);
      return (n == 0) ? 1 : n;
   endfunction

   function automatic vec_t model_edge(bit r, bit ga, logic [3:0] lf,
                                       bit pk, logic [3:0] fl);
      int rem;
      bit blk;
      m_edge++;
      if (r) begin
         m_phase = 0;
         m_end   = '{0, 0, 0};
         m_life  = 1'b0;
         return '0;
      end
      m_life = (m_phase == 3) && pk && fl[1];
      if (!ga) begin
         m_phase = 0;
         m_end   = '{0, 0, 0};
      end else begin
         case (m_phase)
            0: begin
               m_phase    = 1;
               m_spawn_at = m_edge + n_of(lf);
            end
            1: if (m_edge >= m_spawn_at) m_phase = 2;
            2: begin
               m_phase     = 3;
               m_field_end = m_edge + FT;
            end
            default: begin
               if (pk || m_edge >= m_field_end) begin
                  if (pk && fl[0]) m_end[0] = m_edge + ET;
                  if (pk && fl[2]) m_end[1] = m_edge + ET;
                  if (pk && fl[3]) m_end[2] = m_edge + ET;
                  m_phase    = 1;
                  m_spawn_at = m_edge + n_of(lf);
               end
            end
         endcase
      end
      rem = m_field_end - m_edge;
      blk = (m_phase == 3) && (rem <= BT) && rem[3];
      return {m_phase == 2, m_phase == 3, blk,
              m_edge < m_end[0], m_edge < m_end[1], m_edge < m_end[2],
              m_life};
   endfunction

   always @(negedge frame_clk) begin
      if (sb.size() != 0) begin
         vec_t e;
         vec_t a;
         e = sb.pop_front();
         a = outs();
         mon_n++;
         checks++;
         if (a !== e) begin
            errors++;
            $display("FAIL frame%0d outputs got %b want %b (gen vis blink spd sht dbl life)",
                     mon_n, a, e);
         end
      end
   end

   // fl = {doublescore, shootfaster, extralife, speedup}
   task automatic tick(bit ga, logic [3:0] lf, bit pk, logic [3:0] fl);
      @(negedge frame_clk);
      #1;
      Reset             = rst_v;
      bus.game_active   = ga;
      bus.LFSR_interval = lf;
      bus.pickup        = pk;
      {bus.doublescore, bus.shootfaster, bus.extralife, bus.speedup} = fl;
      sb.push_back(model_edge(rst_v, ga, lf, pk, fl));
   endtask

   task automatic wait_field(logic [3:0] lf);
      int n;
      n = 0;
      do begin
         tick(1'b1, lf, 1'b0, 4'h0);
         n++;
      end while (!bus.powerup_visible && n < 200);
      checks++;
      if (!bus.powerup_visible) begin
         errors++;
         $display("FAIL wait_field visible=%b want 1 after %0d frames",
                  bus.powerup_visible, n);
      end
   endtask

   task automatic async_reset();
      @(posedge frame_clk);
      #2;
      Reset = 1'b1;
      #1;
      checks++;
      if (outs() !== 7'b0) begin
         errors++;
         $display("FAIL async_reset outputs got %b want 0000000", outs());
      end
      sb.delete();
      rst_v = 1'b1;
      tick(1'b0, 4'h0, 1'b0, 4'h0);
      tick(1'b0, 4'h0, 1'b0, 4'h0);
      rst_v = 1'b0;
   endtask

   initial begin
      int gen_at;
      int off;
      bit ga;
      bit pk;
      bus.game_active   = 1'b0;
      bus.LFSR_interval = 4'h0;
      bus.pickup        = 1'b0;
      bus.speedup       = 1'b0;
      bus.extralife     = 1'b0;
      bus.shootfaster   = 1'b0;
      bus.doublescore   = 1'b0;

      repeat (3) tick(1'b0, 4'h0, 1'b0, 4'h0);
      rst_v = 1'b0;
      tick(1'b1, 4'd3, 1'b0, 4'h0);
      gen_at = -1;
      for (int j = 1; j <= 40 && gen_at < 0; j++) begin
         tick(1'b1, 4'd3, 1'b0, 4'h0);
         if (bus.generate_powerup) gen_at = j;
      end
      checks++;
      if (gen_at != 17) begin
         errors++;
         $display("FAIL spawn_latency got edge %0d want 17", gen_at);
      end

      repeat (25) tick(1'b1, 4'h0, 1'b0, 4'h0);

      wait_field(4'h0);
      tick(1'b1, 4'h0, 1'b1, 4'b0001);
      wait_field(4'h0);
      tick(1'b1, 4'h0, 1'b1, 4'b0001);

      wait_field(4'h0);
      tick(1'b1, 4'h0, 1'b1, 4'b0010);
      for (int j = 0; j < 60; j++) begin
         tick(1'b1, 4'h0, 1'b1, 4'b1101);
         if (bus.generate_powerup) break;
      end

      wait_field(4'h0);
      repeat (18) tick(1'b1, 4'h0, 1'b0, 4'h0);
      tick(1'b1, 4'h0, 1'b1, 4'b1000);
      wait_field(4'h0);
      tick(1'b1, 4'h0, 1'b1, 4'b0100);

      wait_field(4'h0);
      tick(1'b1, 4'h0, 1'b1, 4'b0101);
      wait_field(4'h0);
      tick(1'b0, 4'h0, 1'b0, 4'h0);
      repeat (3) tick(1'b0, 4'h0, 1'b0, 4'h0);

      wait_field(4'd5);
      tick(1'b1, 4'd5, 1'b1, 4'b0001);
      repeat (3) tick(1'b1, 4'd5, 1'b0, 4'h0);
      async_reset();

      off = 0;
      for (int i = 0; i < 1500; i++) begin
         if (off > 0) off--;
         else if ($urandom_range(0, 99) == 0) off = $urandom_range(1, 5);
         ga = (off == 0);
         pk = ga && ($urandom_range(0, 3) == 0);
         tick(ga, 4'($urandom_range(0, 15)), pk, 4'($urandom_range(0, 15)));
      end

      tick(1'b1, 4'h0, 1'b0, 4'h0);
      @(negedge frame_clk);
      #1;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
